// File: rtl/tile_pkg.sv
// Shared tile-board constants, requester indices and the arbiter state type.
package tile_pkg;

   localparam int unsigned TILE_ADDR_W = 4;
   localparam int unsigned TILE_DATA_W = 8;
   localparam int unsigned NUM_TILES   = 16;

   localparam int unsigned REQ_GAME  = 0;
   localparam int unsigned REQ_INIT  = 1;
   localparam int unsigned REQ_MATCH = 2;

   typedef enum logic {ARB_IDLE, ARB_OWNED} arbState_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Reused by the tile RAM, sound and score arbiters.
module rr_picker #(
   parameter int unsigned N     = 3,
   parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     pick,
   output logic             found
);

   // Walk offsets 0..N-1 from ptr; the earliest offset with a request wins.
   always_comb begin
      int unsigned idx;
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = int'(unsigned'(ptr)) + k;
         if (idx >= N) idx = idx - N;
         for (int unsigned j = 0; j < N; j++) begin
            if (!found && req[j] && (j == idx)) begin
               pick[j] = 1'b1;
               found   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tile_ram_arbiter.sv
// Round-robin arbiter for port A of the tile-board RAM with optional multi-cycle
// lock and per-requester tagged read return.
// Optional feature: define TILE_ARB_LOCK_TIMEOUT_EN to force-release a lock held
// for MAX_LOCK cycles and pulse lock_timeout.
module tile_ram_arbiter
   import tile_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 3,
   parameter int unsigned ADDR_W   = TILE_ADDR_W,
   parameter int unsigned DATA_W   = TILE_DATA_W,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned MAX_LOCK = 15
) (
   input  logic                        CLOCK_50,
   input  logic                        resetn,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          lock,
   input  logic [NUM_REQ*ADDR_W-1:0]   addr,
   input  logic [NUM_REQ*DATA_W-1:0]   wdata,
   input  logic [NUM_REQ-1:0]          we,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [NUM_REQ-1:0]          rvalid,
   output logic [DATA_W-1:0]           rdata,
   output logic [ADDR_W-1:0]           ram_addr,
   output logic [DATA_W-1:0]           ram_wdata,
   output logic                        ram_we,
   input  logic [DATA_W-1:0]           ram_rdata,
   output logic                        lock_timeout
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arbState_t          state;
   logic [NUM_REQ-1:0] gntQ, gntD;
   logic [PTR_W-1:0]   ptrQ, ptrD;
   logic [PTR_W-1:0]   ownerIdx, nextPtr, pickPtr;
   logic [NUM_REQ-1:0] pickGnt;
   logic               pickFound;
   logic               access, ownerLock, ownerWe, lockedAccess, relGrant, timeoutHit;
   logic               readIssue;
   logic [ADDR_W-1:0]  muxAddr, addrHoldQ;
   logic [DATA_W-1:0]  muxWdata, wdataHoldQ, rdataHoldQ;
   logic               tagValidQ [RD_LAT];
   logic [PTR_W-1:0]   tagIdxQ   [RD_LAT];

   assign state = (|gntQ) ? ARB_OWNED : ARB_IDLE;
   assign gnt   = gntQ;

   // Decode the owner index and mux its address/data lines.
   always_comb begin
      ownerIdx = '0;
      muxAddr  = '0;
      muxWdata = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gntQ[i]) begin
            ownerIdx = PTR_W'(i);
            muxAddr  = addr[i*ADDR_W +: ADDR_W];
            muxWdata = wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign access       = |(gntQ & req);
   assign ownerLock    = |(gntQ & lock);
   assign ownerWe      = |(gntQ & we);
   assign lockedAccess = access & ownerLock;
   assign readIssue    = access & ~ownerWe;

   // An owner keeps the grant only while it is doing a locked access.
   assign relGrant = (state == ARB_OWNED) & (~lockedAccess | timeoutHit);
   assign nextPtr  = (ownerIdx == PTR_W'(NUM_REQ - 1)) ? '0 : ownerIdx + PTR_W'(1);
   // On release the pick uses the advanced pointer so the next grant has no bubble.
   assign pickPtr  = relGrant ? nextPtr : ptrQ;

   rr_picker #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_picker (
      .req   (req),
      .ptr   (pickPtr),
      .pick  (pickGnt),
      .found (pickFound)
   );

   // Next grant and round-robin pointer.
   always_comb begin
      gntD = gntQ;
      ptrD = ptrQ;
      unique case (state)
         ARB_IDLE: gntD = pickFound ? pickGnt : '0;
         ARB_OWNED: begin
            if (relGrant) begin
               ptrD = nextPtr;
               gntD = pickFound ? pickGnt : '0;
            end
         end
      endcase
   end

   // Grant and pointer state.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         gntQ <= '0;
         ptrQ <= '0;
      end else begin
         gntQ <= gntD;
         ptrQ <= ptrD;
      end
   end

   // RAM port A: live mux during an access, otherwise hold the last address/data.
   assign ram_we    = access & ownerWe;
   assign ram_addr  = access ? muxAddr : addrHoldQ;
   assign ram_wdata = access ? muxWdata : wdataHoldQ;

   // Read tags travel alongside the RAM latency so data returns to the issuer.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned k = 0; k < RD_LAT; k++) begin
            tagValidQ[k] <= 1'b0;
            tagIdxQ[k]   <= '0;
         end
      end else begin
         tagValidQ[0] <= readIssue;
         tagIdxQ[0]   <= ownerIdx;
         for (int unsigned k = 1; k < RD_LAT; k++) begin
            tagValidQ[k] <= tagValidQ[k-1];
            tagIdxQ[k]   <= tagIdxQ[k-1];
         end
      end
   end

   // Decode the tag leaving the pipe into a one-hot valid pulse.
   always_comb begin
      rvalid = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         rvalid[i] = tagValidQ[RD_LAT-1] && (tagIdxQ[RD_LAT-1] == PTR_W'(i));
      end
   end

   assign rdata = (|rvalid) ? ram_rdata : rdataHoldQ;

   // Hold registers for the idle port A lines and the last delivered read word.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         addrHoldQ  <= '0;
         wdataHoldQ <= '0;
         rdataHoldQ <= '0;
      end else begin
         addrHoldQ  <= ram_addr;
         wdataHoldQ <= ram_wdata;
         rdataHoldQ <= rdata;
      end
   end

`ifdef TILE_ARB_LOCK_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

   logic [CNT_W-1:0] holdCntQ, holdCntD;

   // The MAX_LOCK-th consecutive locked cycle is the last one allowed.
   assign timeoutHit   = lockedAccess && (holdCntQ == CNT_W'(MAX_LOCK - 1));
   assign lock_timeout = timeoutHit;

   // Saturating count of locked cycles; cleared whenever the grant is released.
   always_comb begin
      holdCntD = holdCntQ;
      if (relGrant) begin
         holdCntD = '0;
      end else if (lockedAccess && (holdCntQ != CNT_W'(MAX_LOCK))) begin
         holdCntD = holdCntQ + CNT_W'(1);
      end
   end

   // Lock hold counter state.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         holdCntQ <= '0;
      end else begin
         holdCntQ <= holdCntD;
      end
   end
`else
   assign timeoutHit   = 1'b0;
   assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Directed bench for tile_ram_arbiter with a spec-level reference model.
module tb_tile_ram_arbiter;

   localparam int N   = 3;
   localparam int AW  = 4;
   localparam int DW  = 8;
   localparam int LAT = 1;

   logic          CLOCK_50 = 1'b0;
   logic          resetn   = 1'b0;
   logic [N-1:0]  req      = '0;
   logic [N-1:0]  lock     = '0;
   logic [N-1:0]  we       = '0;
   logic [AW-1:0] a  [N];
   logic [DW-1:0] wd [N];
   logic [N*AW-1:0] addrFlat;
   logic [N*DW-1:0] wdataFlat;

   logic [N-1:0]  gnt, rvalid;
   logic [DW-1:0] rdata, ram_wdata, ram_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_we, lock_timeout;

   int nVec = 0;
   int nErr = 0;

   assign addrFlat  = {a[2], a[1], a[0]};
   assign wdataFlat = {wd[2], wd[1], wd[0]};

   always #10 CLOCK_50 = ~CLOCK_50;

   tile_ram_arbiter #(
      .NUM_REQ  (N),
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .RD_LAT   (LAT),
      .MAX_LOCK (15)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .resetn       (resetn),
      .req          (req),
      .lock         (lock),
      .addr         (addrFlat),
      .wdata        (wdataFlat),
      .we           (we),
      .gnt          (gnt),
      .rvalid       (rvalid),
      .rdata        (rdata),
      .ram_addr     (ram_addr),
      .ram_wdata    (ram_wdata),
      .ram_we       (ram_we),
      .ram_rdata    (ram_rdata),
      .lock_timeout (lock_timeout)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Physical RAM seen by the DUT: word i powers up as 8'hA0|i, LAT-cycle read.
   logic [DW-1:0] ram   [16];
   logic [DW-1:0] rpipe [LAT];
   logic          ramLoaded = 1'b0;

   always @(posedge CLOCK_50) begin
      if (!ramLoaded) begin
         for (int i = 0; i < 16; i++) ram[i] <= 8'hA0 | 8'(i);
         ramLoaded <= 1'b1;
      end else if (ram_we) begin
         ram[ram_addr] <= ram_wdata;
      end
      rpipe[0] <= ram[ram_addr];
      for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
   end
   assign ram_rdata = rpipe[LAT-1];

   // Reference model: owner/pointer as integers, reads as a queue of due deliveries.
   typedef struct {
      int            due;
      int            who;
      logic [DW-1:0] data;
   } rd_t;

   rd_t           dq [$];
   int            mOwner = -1;
   int            mPtr   = 0;
   int            mCyc   = 0;
   logic [AW-1:0] mLastAddr = '0;
   logic [DW-1:0] mLastWd   = '0;
   logic [DW-1:0] mMem [16];
   logic          mInit = 1'b0;

   always @(negedge CLOCK_50) begin
      logic [N-1:0]  expRv;
      logic [DW-1:0] expRd;
      logic          acc;
      logic [AW-1:0] expAddr;
      logic [DW-1:0] expWd;
      int            start;
      bit            rel;
      if (!mInit) begin
         for (int i = 0; i < 16; i++) mMem[i] = 8'hA0 | 8'(i);
         mInit = 1'b1;
      end
      if (!resetn) begin
         mOwner = -1;
         mPtr = 0;
         dq.delete();
         mLastAddr = '0;
         mLastWd = '0;
         check("rst_gnt", 32'(gnt), 32'd0);
         check("rst_rvalid", 32'(rvalid), 32'd0);
         check("rst_rdata", 32'(rdata), 32'd0);
         check("rst_ram_we", 32'(ram_we), 32'd0);
         check("rst_ram_addr", 32'(ram_addr), 32'd0);
         check("rst_timeout", 32'(lock_timeout), 32'd0);
      end else begin
         expRv = '0;
         expRd = '0;
         if (dq.size() > 0 && dq[0].due == mCyc) begin
            expRv = N'(1 << dq[0].who);
            expRd = dq[0].data;
            void'(dq.pop_front());
         end
         check("gnt", 32'(gnt), (mOwner < 0) ? 32'd0 : 32'(1 << mOwner));
         check("rvalid", 32'(rvalid), 32'(expRv));
         if (expRv != '0) check("rdata", 32'(rdata), 32'(expRd));
         acc = (mOwner >= 0) && req[mOwner];
         expAddr = acc ? a[mOwner] : mLastAddr;
         expWd   = acc ? wd[mOwner] : mLastWd;
         check("ram_we", 32'(ram_we), 32'(acc && we[mOwner]));
         check("ram_addr", 32'(ram_addr), 32'(expAddr));
         check("ram_wdata", 32'(ram_wdata), 32'(expWd));
         check("lock_timeout", 32'(lock_timeout), 32'd0);
         if (acc) begin
            if (we[mOwner]) mMem[expAddr] = expWd;
            else dq.push_back('{due: mCyc + LAT, who: mOwner, data: mMem[expAddr]});
         end
         mLastAddr = expAddr;
         mLastWd   = expWd;
         rel = (mOwner >= 0) && !(acc && lock[mOwner]);
         if (mOwner < 0 || rel) begin
            if (rel) mPtr = (mOwner + 1) % N;
            start  = mPtr;
            mOwner = -1;
            for (int k = 0; k < N; k++) begin
               if (mOwner < 0 && req[(start + k) % N]) mOwner = (start + k) % N;
            end
         end
      end
      mCyc++;
   end

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         a[i]  = '0;
         wd[i] = '0;
      end
      // Reset held with all requesting.
      req = 3'b111;
      repeat (3) @(negedge CLOCK_50);
      check("pin_reset_gnt", 32'(gnt), 32'd0);
      check("pin_reset_rvalid", 32'(rvalid), 32'd0);
      check("pin_reset_we", 32'(ram_we), 32'd0);

      // Round-robin reads, no bubbles.
      a[0] = 4'd1; a[1] = 4'd2; a[2] = 4'd4;
      step(); resetn = 1'b1;
      @(negedge CLOCK_50); check("pin_release_lag", 32'(gnt), 32'd0);
      @(negedge CLOCK_50); check("pin_rr0", 32'(gnt), 32'b001);
      @(negedge CLOCK_50); check("pin_rr1", 32'(gnt), 32'b010);
      check("pin_rr1_rv", 32'(rvalid), 32'b001); check("pin_rr1_rd", 32'(rdata), 32'hA1);
      @(negedge CLOCK_50); check("pin_rr2", 32'(gnt), 32'b100);
      check("pin_rr2_rv", 32'(rvalid), 32'b010); check("pin_rr2_rd", 32'(rdata), 32'hA2);
      @(negedge CLOCK_50); check("pin_rr3", 32'(gnt), 32'b001);
      check("pin_rr3_rv", 32'(rvalid), 32'b100); check("pin_rr3_rd", 32'(rdata), 32'hA4);
      step(); req = 3'b000;
      @(negedge CLOCK_50); check("pin_rr4_rv", 32'(rvalid), 32'b001);
      step();

      // Lock swap by requester 0 while requester 1 waits.
      req = 3'b011; lock = 3'b001; we = 3'b000; a[0] = 4'd3; a[1] = 4'd2;
      step();
      @(negedge CLOCK_50); check("pin_lock_gnt0", 32'(gnt), 32'b001);
      step(); a[0] = 4'd7;
      @(negedge CLOCK_50); check("pin_lock_rd3", 32'(rdata), 32'hA3);
      step(); we = 3'b001; a[0] = 4'd3; wd[0] = 8'h15;
      @(negedge CLOCK_50); check("pin_lock_hold", 32'(gnt), 32'b001);
      check("pin_lock_rd7", 32'(rdata), 32'hA7);
      step(); a[0] = 4'd7; wd[0] = 8'h2A; lock = 3'b000;
      @(negedge CLOCK_50); check("pin_lock_last", 32'(gnt), 32'b001);
      step(); req = 3'b010; we = 3'b000;
      @(negedge CLOCK_50); check("pin_lock_handoff", 32'(gnt), 32'b010);
      step(); req = 3'b000;
      step();
      check("pin_ram3", 32'(ram[3]), 32'h15);
      check("pin_ram7", 32'(ram[7]), 32'h2A);

      // Read tag survives a grant move to requester 2.
      req = 3'b001; a[0] = 4'd5;
      step(); req = 3'b101; a[2] = 4'd9; wd[2] = 8'h77; we = 3'b100;
      @(negedge CLOCK_50); check("pin_tag_gnt0", 32'(gnt), 32'b001);
      step(); req = 3'b100;
      @(negedge CLOCK_50); check("pin_tag_gnt2", 32'(gnt), 32'b100);
      check("pin_tag_rv", 32'(rvalid), 32'b001); check("pin_tag_rd", 32'(rdata), 32'hA5);
      step(); req = 3'b000; we = 3'b000;
      @(negedge CLOCK_50); check("pin_write_no_rv", 32'(rvalid), 32'b000);

      // Reset one cycle after a read issue drops the delivery.
      step(); req = 3'b010; a[1] = 4'd6;
      step();
      @(negedge CLOCK_50); check("pin_mid_gnt1", 32'(gnt), 32'b010);
      step(); resetn = 1'b0; req = 3'b000;
      @(negedge CLOCK_50); check("pin_mid_rv", 32'(rvalid), 32'b000);
      check("pin_mid_gnt", 32'(gnt), 32'b000);
      step(); step(); resetn = 1'b1;
      repeat (4) @(negedge CLOCK_50);
      check("pin_ram9", 32'(ram[9]), 32'h77);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule

// File: doc/tile_ram_arbiter.md
Name: tile_ram_arbiter

Overview:
Shares the single read/write port of the 16-entry x 8-bit tile-board RAM between several CLOCK_50-domain requesters. Requesters are the in-game FSM, the board initialiser/shuffler and the match checker. The block does round-robin arbitration with an optional multi-cycle lock for read-modify-write sequences such as swapping or flipping two tiles. It also returns read data tagged to the requester that issued the read. It sits between those FSMs and port A of the tile RAM; the VGA read port C is untouched.

Parameters:
NUM_REQ, 3, number of requesters (index 0 = in-game FSM, 1 = initialiser, 2 = match checker)
ADDR_W, 4, tile RAM address width (16 tiles)
DATA_W, 8, tile word width
RD_LAT, 1, RAM read latency in cycles (1..3 supported)
MAX_LOCK, 15, lock timeout in cycles (used only with the optional feature)

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester access request, level
lock  in  NUM_REQ  per-requester: keep grant after current access
addr  in  NUM_REQ*ADDR_W  flattened per-requester address
wdata  in  NUM_REQ*DATA_W  flattened per-requester write data
we  in  NUM_REQ  per-requester write enable (0 = read)
gnt  out  NUM_REQ  one-hot grant, registered
rvalid  out  NUM_REQ  one-cycle read-data-valid pulse to issuing requester
rdata  out  DATA_W  read data, shared, valid when any rvalid bit is set
ram_addr  out  ADDR_W  to RAM port A
ram_wdata  out  DATA_W  to RAM port A
ram_we  out  1  to RAM port A
ram_rdata  in  DATA_W  from RAM port A
lock_timeout  out  1  one-cycle pulse on forced revoke (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (resetn low, async): gnt=0, rvalid=0, rdata=0, ram_we=0, ram_addr=0, ram_wdata=0, RR pointer=0 (requester 0 highest priority), lock_timeout=0, read-tag pipe cleared.
- States: IDLE (no grant), OWNED (one gnt bit set).
- IDLE -> OWNED: if any req is set, next cycle gnt = first requesting index at or after the RR pointer, wrapping. A request seen in cycle N gets its grant in cycle N+1.
- Access: a cycle with gnt[i] & req[i] issues exactly one RAM access.
  - ram_addr, ram_wdata and ram_we are muxed combinationally from requester i.
  - ram_we = we[i].
  - Outside an access cycle, ram_we=0 and ram_addr/ram_wdata hold their last values.
- Release: after an access with lock[i]=0, or in any cycle with gnt[i] and req[i]=0:
  - RR pointer moves to i+1 mod NUM_REQ.
  - Next grant is chosen in the same cycle, so back-to-back grants to another requester have no bubble.
  - If nothing else is requesting and req[i] stays high, i is granted again.
- Lock: while gnt[i] & req[i] & lock[i], the grant is held. Accesses continue one per cycle and other requesters wait.
- Reads: a read access in cycle N pushes tag i into an RD_LAT-deep pipe.
  - Cycle N+RD_LAT: rvalid[i]=1 and rdata=ram_rdata, both registered from the RAM output stage.
  - Delivery is correct even if the grant has already moved.
- Writes produce no rvalid.
- Simultaneous requests: exactly one grant, chosen by RR order. Fairness: with every requester continuously requesting and lock=0, each gets a grant at least once every NUM_REQ grants.
- Reset mid-lock or mid-read: all state clears and any in-flight rvalid is dropped. Requesters must reissue.
- gnt is always one-hot or zero; never multi-hot.

Optional Feature:
TILE_ARB_LOCK_TIMEOUT_EN
- Defined:
  - A saturating counter counts consecutive cycles of one locked grant.
  - After MAX_LOCK cycles held, the grant is force-released as if lock were 0, RR advances, and lock_timeout pulses for 1 cycle.
  - The counter resets on every grant change.
- Undefined: a lock is held indefinitely, no counter is built, and lock_timeout is tied 0.

Decomposition:
- Shared package tile_pkg:
  - TILE_ADDR_W=4, TILE_DATA_W=8, NUM_TILES=16.
  - Requester index constants REQ_GAME=0, REQ_INIT=1, REQ_MATCH=2.
  - State enum {ARB_IDLE, ARB_OWNED}.
- One natural sub-module: rr_picker. It is combinational: it takes the req vector and the pointer and returns a one-hot next grant and a found flag. It is reused by the future sound/score arbiters.

Test Plan:
- Reset: hold resetn=0 with req=3'b111 -> gnt=0, rvalid=0, ram_we=0. Release -> gnt=3'b001 one cycle later.
- Round-robin: req=3'b111, lock=0, all reads, continuous -> gnt sequence 001,010,100,001 with no idle cycle, and each rvalid arrives RD_LAT cycles after its access.
- Lock swap: requester 0 locks and does read 3, read 7, write 3=8'h15, write 7=8'h2A while req[1]=1. Requester 1 gets no grant until lock drops, then gnt=010 next cycle. A RAM model shows addr3=8'h15 and addr7=8'h2A.
- Tagged read after grant move: req0 reads addr 5 (RAM=8'hA5) then drops req, and req2 is granted immediately -> rvalid=3'b001 with rdata=8'hA5 at N+RD_LAT, no rvalid to requester 2.
- Reset mid-read: assert resetn low 1 cycle after a read issue -> no rvalid ever appears and gnt=0.
- With TILE_ARB_LOCK_TIMEOUT_EN, MAX_LOCK=15: requester 1 holds lock 20 cycles while req0=1 -> lock_timeout pulses at the 15th held cycle and gnt switches to 001 next cycle.
